// File: rtl/mux_2_to_1_pkg.sv
// -----------------------------------------------------------------------------
// mux_2_to_1_pkg
// Shared constants and the select helper for the 2:1 data selector.
//
// Contents:
//   SEL_D0 / SEL_D1 : select encodings (s0 = 0 picks d0, s0 = 1 picks d1)
//   sel2()          : single-bit 2:1 select. Callers apply it bit by bit, so
//                     the combinational output and the registered path of any
//                     width share exactly the same select logic.
// -----------------------------------------------------------------------------
package mux_2_to_1_pkg;

  localparam logic SEL_D0 = 1'b0;
  localparam logic SEL_D1 = 1'b1;

  // Picks d1 when s selects it and d0 otherwise.
  function automatic logic sel2(input logic d0, input logic d1, input logic s);
    return (s == SEL_D1) ? d1 : d0;
  endfunction

endpackage

// File: rtl/mux_2_to_1_skid.sv
// -----------------------------------------------------------------------------
// mux_2_to_1_skid
// Generic WIDTH-wide, 2-entry valid/ready skid buffer (main + skid entry).
// The main entry drives the output. The skid entry catches a beat that was
// accepted while the main entry was stalled. in_ready_o is registered, so it
// has no combinational path from out_ready_i.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   in_valid_i   in   upstream beat valid
//   in_ready_o   out  buffer can accept (registered, !skid_full)
//   in_data_i    in   upstream beat data (WIDTH)
//   out_valid_o  out  main entry holds a beat
//   out_ready_i  in   downstream accepts the main entry
//   out_data_o   out  main entry data (WIDTH), RESET_VAL after reset
// -----------------------------------------------------------------------------
module mux_2_to_1_skid #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  logic             mainValid_q, mainValid_d;
  logic [WIDTH-1:0] mainData_q,  mainData_d;
  logic             skidValid_q, skidValid_d;
  logic [WIDTH-1:0] skidData_q,  skidData_d;
  logic             inReady_q,   inReady_d;
  logic             accept;
  logic             emit;

  assign accept = in_valid_i && inReady_q;
  assign emit   = mainValid_q && out_ready_i;

  // Next-state for the two entries. The skid entry is only ever filled while
  // the main entry is full, so "skid full" implies "main full". When the skid
  // entry is full the input is blocked, and a drain moves skid into main on
  // the same edge. With only main full, a simultaneous accept and emit simply
  // replaces main, which keeps a full-throughput stream in one entry.
  always_comb begin
    mainValid_d = mainValid_q;
    mainData_d  = mainData_q;
    skidValid_d = skidValid_q;
    skidData_d  = skidData_q;

    if (skidValid_q) begin
      if (emit) begin
        mainData_d  = skidData_q;
        skidValid_d = 1'b0;
      end
    end else if (mainValid_q) begin
      if (emit && accept) begin
        mainData_d = in_data_i;
      end else if (emit) begin
        mainValid_d = 1'b0;
      end else if (accept) begin
        skidValid_d = 1'b1;
        skidData_d  = in_data_i;
      end
    end else if (accept) begin
      mainValid_d = 1'b1;
      mainData_d  = in_data_i;
    end

    inReady_d = !skidValid_d;
  end

  // State registers. inReady_q resets low and rises on the first clock after
  // reset is released, so nothing is accepted while reset is active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mainValid_q <= 1'b0;
      mainData_q  <= RESET_VAL;
      skidValid_q <= 1'b0;
      skidData_q  <= '0;
      inReady_q   <= 1'b0;
    end else begin
      mainValid_q <= mainValid_d;
      mainData_q  <= mainData_d;
      skidValid_q <= skidValid_d;
      skidData_q  <= skidData_d;
      inReady_q   <= inReady_d;
    end
  end

  assign in_ready_o  = inReady_q;
  assign out_valid_o = mainValid_q;
  assign out_data_o  = mainData_q;

endmodule

// File: rtl/mux_2_to_1.sv
// -----------------------------------------------------------------------------
// mux_2_to_1
// Parameterised 2:1 data selector with two outputs:
//   - a combinational result y = s0 ? d1 : d0
//   - a registered copy y_q behind a valid/ready handshake and a 2-entry
//     skid buffer, for use as a pipeline stage
//
// Optional build macro: MUX_2_TO_1_PARITY_EN adds y_par, the XOR-reduce of
// y_q. It is carried through the skid buffer with its beat.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   d0, d1     in   data inputs (WIDTH)
//   s0         in   select (0 -> d0, 1 -> d1)
//   y          out  combinational mux result (WIDTH)
//   in_valid   in   d0/d1/s0 valid for the registered path
//   in_ready   out  stage can accept
//   y_q        out  registered mux result (WIDTH), RESET_VAL after reset
//   out_valid  out  y_q valid
//   out_ready  in   downstream accepts y_q
//   y_par      out  parity of y_q (only with MUX_2_TO_1_PARITY_EN)
// -----------------------------------------------------------------------------
module mux_2_to_1
  import mux_2_to_1_pkg::*;
#(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic             s0,
  output logic [WIDTH-1:0] y,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y_q,
  output logic             out_valid,
  input  logic             out_ready
`ifdef MUX_2_TO_1_PARITY_EN
  ,
  output logic             y_par
`endif
);

  logic [WIDTH-1:0] selData;

  // The select is applied bit by bit through the shared helper. The same
  // result feeds both the combinational output and the skid buffer.
  always_comb begin
    selData = '0;
    for (int i = 0; i < WIDTH; i++) begin
      selData[i] = sel2(d0[i], d1[i], s0);
    end
  end

  assign y = selData;

`ifdef MUX_2_TO_1_PARITY_EN
  // Parity rides as an extra top bit so it always stays with its own beat.
  localparam logic [WIDTH:0] SKID_RESET = {^RESET_VAL, RESET_VAL};

  logic [WIDTH:0] skidOut;

  mux_2_to_1_skid #(
    .WIDTH     (WIDTH + 1),
    .RESET_VAL (SKID_RESET)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   ({^selData, selData}),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (skidOut)
  );

  assign y_q   = skidOut[WIDTH-1:0];
  assign y_par = skidOut[WIDTH];
`else
  mux_2_to_1_skid #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (selData),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (y_q)
  );
`endif

endmodule

// File: tb/tb_mux_2_to_1.sv
// -----------------------------------------------------------------------------
// tb_mux_2_to_1
// Self-checking bench for mux_2_to_1. A WIDTH=1 instance covers the truth
// table. A WIDTH=8 instance (RESET_VAL=8'h5A) covers the registered
// handshake path, which is checked against a reference FIFO of capacity 2.
// With MUX_2_TO_1_PARITY_EN defined, y_par is checked as well.
// -----------------------------------------------------------------------------
module tb_mux_2_to_1;

  localparam logic [7:0] RV = 8'h5A;

  logic       clk;
  logic       rst_n;

  // Wide instance signals
  logic [7:0] d0, d1, y, y_q;
  logic       s0, in_valid, in_ready, out_valid, out_ready;

  // Narrow (WIDTH=1) instance signals
  logic       nD0, nD1, nS0, nY, nIv, nIr, nYq, nOv, nOr;

`ifdef MUX_2_TO_1_PARITY_EN
  logic       y_par, nYPar;
`endif

  int         compared   = 0;
  int         mismatched = 0;

  // Reference model: the registered path behaves as a FIFO of capacity 2.
  // Its head is what y_q shows, and it is ready whenever it is not full.
  logic [7:0] mq[$];
  logic       expReady;
  logic       lastAcc;

  mux_2_to_1 #(.WIDTH(8), .RESET_VAL(RV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .d0        (d0),
    .d1        (d1),
    .s0        (s0),
    .y         (y),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y_q       (y_q),
    .out_valid (out_valid),
`ifdef MUX_2_TO_1_PARITY_EN
    .y_par     (y_par),
`endif
    .out_ready (out_ready)
  );

  mux_2_to_1 #(.WIDTH(1)) dutNarrow (
    .clk       (clk),
    .rst_n     (rst_n),
    .d0        (nD0),
    .d1        (nD1),
    .s0        (nS0),
    .y         (nY),
    .in_valid  (nIv),
    .in_ready  (nIr),
    .y_q       (nYq),
    .out_valid (nOv),
`ifdef MUX_2_TO_1_PARITY_EN
    .y_par     (nYPar),
`endif
    .out_ready (nOr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drives one cycle of stimulus on the wide instance starting at a negedge,
  // advances the reference FIFO at the posedge, and returns at the next negedge.
  task automatic applyStimulus(input logic iv, input logic [7:0] a, input logic [7:0] b,
                               input logic s, input logic ordy);
    in_valid  = iv;
    d0        = a;
    d1        = b;
    s0        = s;
    out_ready = ordy;
    @(posedge clk);
    lastAcc = 1'b0;
    if (rst_n) begin
      lastAcc = iv && expReady;
      if ((mq.size() > 0) && ordy) void'(mq.pop_front());
      if (lastAcc) mq.push_back(s ? b : a);
      expReady = (mq.size() < 2);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    mq.delete();
    expReady = 1'b0;
    #1;
    compared++; if (in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_in_ready: got %b want 0", in_ready); end
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
    compared++; if (y_q !== RV) begin mismatched++; $display("[TB] FAIL reset_y_q: got %h want %h", y_q, RV); end
    compared++; if (nYq !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_narrow_y_q: got %b want 0", nYq); end
    compared++; if (nOv !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_narrow_out_valid: got %b want 0", nOv); end
    compared++; if (nIr !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_narrow_in_ready: got %b want 0", nIr); end
`ifdef MUX_2_TO_1_PARITY_EN
    compared++; if (y_par !== ^RV) begin mismatched++; $display("[TB] FAIL reset_y_par: got %b want %b", y_par, ^RV); end
    compared++; if (nYPar !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_narrow_y_par: got %b want 0", nYPar); end
`endif
  endtask

  // Truth table sweep, run while reset is asserted to show y ignores it.
  task automatic test_comb_sweep();
    logic [2:0] pat  [8];
    logic       expY [8];
    logic [7:0] a, b;
    logic       s;
    pat  = '{3'b000, 3'b010, 3'b100, 3'b110, 3'b001, 3'b011, 3'b101, 3'b111};
    expY = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      nD0 = pat[i][2];
      nD1 = pat[i][1];
      nS0 = pat[i][0];
      a = 8'($urandom());
      b = 8'($urandom());
      s = 1'($urandom());
      d0 = a;
      d1 = b;
      s0 = s;
      #5;
      compared++; if (nY !== expY[i]) begin mismatched++; $display("[TB] FAIL comb_truth_table[%0d]: got %b want %b", i, nY, expY[i]); end
      compared++; if (y !== (s ? b : a)) begin mismatched++; $display("[TB] FAIL comb_wide[%0d]: got %h want %h", i, y, (s ? b : a)); end
      #5;
    end
  endtask

  task automatic test_release();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL release_in_ready: got %b want 1", in_ready); end
    compared++; if (nIr !== 1'b1) begin mismatched++; $display("[TB] FAIL release_narrow_in_ready: got %b want 1", nIr); end
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL release_out_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_basic8();
    applyStimulus(1'b1, 8'hA5, 8'h3C, 1'b1, 1'b1);
    compared++; if (y_q !== 8'h3C) begin mismatched++; $display("[TB] FAIL basic_sel_d1: got %h want 3c", y_q); end
    compared++; if (out_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL basic_valid1: got %b want 1", out_valid); end
    applyStimulus(1'b1, 8'hA5, 8'h3C, 1'b0, 1'b1);
    compared++; if (y_q !== 8'hA5) begin mismatched++; $display("[TB] FAIL basic_sel_d0: got %h want a5", y_q); end
    compared++; if (y !== 8'hA5) begin mismatched++; $display("[TB] FAIL basic_comb_y: got %h want a5", y); end
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [7:0] a[3], b[3], e[3], got[3];
    logic       s[3];
    logic       acc2;
    int         n;
    for (int i = 0; i < 3; i++) begin
      a[i] = 8'($urandom());
      b[i] = 8'($urandom());
      s[i] = 1'($urandom());
      e[i] = s[i] ? b[i] : a[i];
    end
    applyStimulus(1'b1, a[0], b[0], s[0], 1'b0);
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_ready_after_first: got %b want 1", in_ready); end
    compared++; if (y_q !== e[0]) begin mismatched++; $display("[TB] FAIL bp_first_out: got %h want %h", y_q, e[0]); end
    applyStimulus(1'b1, a[1], b[1], s[1], 1'b0);
    compared++; if (in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_ready_after_second: got %b want 0", in_ready); end
    applyStimulus(1'b1, a[2], b[2], s[2], 1'b0);
    compared++; if (in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_third_blocked: got %b want 0", in_ready); end
    compared++; if ((y_q !== e[0]) || (out_valid !== 1'b1)) begin mismatched++; $display("[TB] FAIL bp_hold_stable: got %h/%b want %h/1", y_q, out_valid, e[0]); end
    acc2 = 1'b0;
    n = 0;
    for (int c = 0; (c < 12) && (n < 3); c++) begin
      if (out_valid === 1'b1) begin
        got[n] = y_q;
        n++;
      end
      applyStimulus(!acc2, a[2], b[2], s[2], 1'b1);
      if (lastAcc) acc2 = 1'b1;
    end
    compared++; if (n !== 3) begin mismatched++; $display("[TB] FAIL bp_emit_count: got %0d want 3", n); end
    for (int i = 0; i < 3; i++) begin
      compared++; if (got[i] !== e[i]) begin mismatched++; $display("[TB] FAIL bp_order[%0d]: got %h want %h", i, got[i], e[i]); end
    end
    compared++; if (acc2 !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_third_accepted: got %b want 1", acc2); end
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_drained: got %b want 0", out_valid); end
  endtask

  task automatic test_random();
    logic [7:0] a, b;
    logic       s, iv, ordy;
    a = 8'($urandom()); b = 8'($urandom()); s = 1'($urandom()); iv = 1'b0;
    for (int c = 0; c < 80; c++) begin
      if (!(iv && !lastAcc) || (c == 0)) begin
        a  = 8'($urandom());
        b  = 8'($urandom());
        s  = 1'($urandom());
        iv = ($urandom_range(0, 3) != 0);
      end
      ordy = ($urandom_range(0, 2) != 0);
      applyStimulus(iv, a, b, s, ordy);
      compared++; if (out_valid !== (mq.size() > 0)) begin mismatched++; $display("[TB] FAIL rnd_valid[%0d]: got %b want %b", c, out_valid, (mq.size() > 0)); end
      compared++; if (in_ready !== expReady) begin mismatched++; $display("[TB] FAIL rnd_ready[%0d]: got %b want %b", c, in_ready, expReady); end
      compared++; if (y !== (s ? b : a)) begin mismatched++; $display("[TB] FAIL rnd_comb[%0d]: got %h want %h", c, y, (s ? b : a)); end
      if (mq.size() > 0) begin
        compared++; if (y_q !== mq[0]) begin mismatched++; $display("[TB] FAIL rnd_data[%0d]: got %h want %h", c, y_q, mq[0]); end
`ifdef MUX_2_TO_1_PARITY_EN
        compared++; if (y_par !== ^mq[0]) begin mismatched++; $display("[TB] FAIL rnd_parity[%0d]: got %b want %b", c, y_par, ^mq[0]); end
`endif
      end
    end
    for (int c = 0; (c < 4) && (mq.size() > 0); c++) applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL rnd_final_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_midstream();
    logic [7:0] a, b;
    a = 8'($urandom());
    b = 8'($urandom());
    applyStimulus(1'b1, a, b, 1'b0, 1'b0);
    applyStimulus(1'b1, b, a, 1'b0, 1'b0);
    compared++; if ((in_ready !== 1'b0) || (out_valid !== 1'b1)) begin mismatched++; $display("[TB] FAIL mid_full: got ready=%b valid=%b want 0/1", in_ready, out_valid); end
    #2 rst_n = 1'b0;
    mq.delete();
    expReady = 1'b0;
    #1;
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_reset_valid: got %b want 0", out_valid); end
    compared++; if (y_q !== RV) begin mismatched++; $display("[TB] FAIL mid_reset_y_q: got %h want %h", y_q, RV); end
    compared++; if (in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_reset_ready: got %b want 0", in_ready); end
    @(negedge clk);
    applyStimulus(1'b1, a, b, 1'b1, 1'b1);
    compared++; if ((out_valid !== 1'b0) || (in_ready !== 1'b0)) begin mismatched++; $display("[TB] FAIL mid_held_in_reset: got valid=%b ready=%b want 0/0", out_valid, in_ready); end
    rst_n = 1'b1;
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    compared++; if ((in_ready !== 1'b1) || (out_valid !== 1'b0)) begin mismatched++; $display("[TB] FAIL mid_after_release: got ready=%b valid=%b want 1/0", in_ready, out_valid); end
    applyStimulus(1'b1, a, b, 1'b1, 1'b1);
    compared++; if ((out_valid !== 1'b1) || (y_q !== b)) begin mismatched++; $display("[TB] FAIL mid_first_beat: got %h/%b want %h/1", y_q, out_valid, b); end
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [7:0] a, b;
    logic       s;
    int         emitted;
    emitted = 0;
    for (int i = 0; i < 16; i++) begin
      a = 8'($urandom());
      b = 8'($urandom());
      s = 1'($urandom());
      applyStimulus(1'b1, a, b, s, 1'b1);
      if (out_valid === 1'b1) emitted++;
      compared++; if ((y_q !== (s ? b : a)) || (out_valid !== 1'b1)) begin mismatched++; $display("[TB] FAIL b2b_beat[%0d]: got %h/%b want %h/1", i, y_q, out_valid, (s ? b : a)); end
      compared++; if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_ready[%0d]: got %b want 1", i, in_ready); end
    end
    compared++; if (emitted !== 16) begin mismatched++; $display("[TB] FAIL b2b_throughput: got %0d want 16", emitted); end
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_drain: got %b want 0", out_valid); end
  endtask

`ifdef MUX_2_TO_1_PARITY_EN
  task automatic test_parity();
    applyStimulus(1'b1, 8'h07, 8'h00, 1'b0, 1'b1);
    compared++; if ((y_q !== 8'h07) || (y_par !== 1'b1)) begin mismatched++; $display("[TB] FAIL parity_07: got %h/%b want 07/1", y_q, y_par); end
    applyStimulus(1'b1, 8'h03, 8'hFF, 1'b0, 1'b1);
    compared++; if ((y_q !== 8'h03) || (y_par !== 1'b0)) begin mismatched++; $display("[TB] FAIL parity_03: got %h/%b want 03/0", y_q, y_par); end
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
  endtask
`endif

  initial begin
    in_valid  = 1'b0;
    out_ready = 1'b1;
    d0 = 8'h00; d1 = 8'h00; s0 = 1'b0;
    nD0 = 1'b0; nD1 = 1'b0; nS0 = 1'b0;
    nIv = 1'b0; nOr = 1'b1;
    lastAcc  = 1'b0;
    expReady = 1'b0;

    test_reset();
    test_comb_sweep();
    test_release();
    test_basic8();
    test_backpressure();
    test_random();
    test_reset_midstream();
    test_back_to_back();
`ifdef MUX_2_TO_1_PARITY_EN
    test_parity();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
